// File: rtl/adc_cap_pkg.sv
// Shared definitions for the ADC capture sequencer: state encoding and default widths.
package adc_cap_pkg;

   localparam int DATA_W = 12;
   localparam int ADDR_W = 10;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ARMED   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = S_IDLE,
      ARMED   = S_ARMED,
      CAPTURE = S_CAPTURE,
      DONE    = S_DONE
   } cap_state_t;

endpackage

// File: rtl/adc_decim_strobe.sv
// Decimation strobe: fires once every decim+1 cycles, first strobe on the cycle clear drops.
module adc_decim_strobe #(
   parameter int DEC_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [DEC_W-1:0] decim,
   output logic             strobe
);

   logic [DEC_W-1:0] cnt;

   // Down-counter reloaded with decim at each terminal count, giving a period of decim+1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (cnt == '0) begin
         cnt <= decim;
      end else begin
         cnt <= cnt - DEC_W'(1);
      end
   end

   assign strobe = (cnt == '0);

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: arm, wait for trigger, write a programmed number of (decimated) samples to RAM.
// Define ADC_CAPTURE_LEVEL_TRIG_EN to add a rising level-crossing trigger on adc_data.
//
// state   | meaning
// IDLE    | waiting for start
// ARMED   | cap_len/decim latched, waiting for trigger
// CAPTURE | writing samples on each decimation strobe
// DONE    | last write issued, emit done pulse then return to IDLE
module adc_capture_ctrl #(
   parameter int DATA_W = adc_cap_pkg::DATA_W,
   parameter int ADDR_W = adc_cap_pkg::ADDR_W,
   parameter int DEC_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              ext_trig,
   input  logic [ADDR_W-1:0] cap_len,
   input  logic [DEC_W-1:0]  decim,
   input  logic [DATA_W-1:0] adc_data,
   input  logic [DATA_W-1:0] trig_level,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done
);

   import adc_cap_pkg::*;

   cap_state_t        state;
   logic [ADDR_W-1:0] len_l;
   logic [DEC_W-1:0]  decim_l;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   remain;
   logic [ADDR_W:0]   depth;
   logic              strobe;
   logic              trig_hit;

   assign depth = (len_l == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, len_l};

   adc_decim_strobe #(.DEC_W(DEC_W)) u_decim (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (state != CAPTURE),
      .decim  (decim_l),
      .strobe (strobe)
   );

`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
   logic [DATA_W-1:0] prev_sample;

   // Held at all ones outside ARMED so the first armed cycle never sees a crossing.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_sample <= '1;
      end else if (state == ARMED) begin
         prev_sample <= adc_data;
      end else begin
         prev_sample <= '1;
      end
   end

   assign trig_hit = ext_trig | ((prev_sample < trig_level) && (adc_data >= trig_level));
`else
   logic unused_trig_level;
   assign unused_trig_level = ^trig_level;
   assign trig_hit = ext_trig;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         len_l   <= '0;
         decim_l <= '0;
         ptr     <= '0;
         remain  <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state   <= ARMED;
                  len_l   <= cap_len;
                  decim_l <= decim;
                  busy    <= 1'b1;
               end
            end
            ARMED: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (trig_hit) begin
                  state  <= CAPTURE;
                  ptr    <= '0;
                  remain <= depth;
               end
            end
            CAPTURE: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (strobe) begin
                  wr_en   <= 1'b1;
                  wr_data <= adc_data;
                  wr_addr <= ptr;
                  ptr     <= ptr + ADDR_W'(1);
                  remain  <= remain - (ADDR_W+1)'(1);
                  if (remain == (ADDR_W+1)'(1)) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with a 4-bit address so full-depth capture stays short.
module tb_adc_capture_ctrl;

   localparam int DW   = 12;
   localparam int AW   = 4;
   localparam int DECW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          ext_trig = 1'b0;
   logic [AW-1:0] cap_len = '0;
   logic [DECW-1:0] decim = '0;
   logic [DW-1:0] adc_data = '0;
   logic [DW-1:0] trig_level = '0;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          busy;
   logic          done;

   adc_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEC_W(DECW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .ext_trig   (ext_trig),
      .cap_len    (cap_len),
      .decim      (decim),
      .adc_data   (adc_data),
      .trig_level (trig_level),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   wa[$];
   int   wd[$];
   int   wc[$];
   int   ndone = 0;
   int   done_cyc = 0;
   int   tcyc = 0;
   int   nsave = 0;
   logic busy_at_done = 1'b0;
   logic busy_before_done = 1'b0;
   logic prev_busy = 1'b0;
   logic ramp = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock: sample outputs 1ns after the edge, then advance the ramp.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (wr_en) begin
         wa.push_back(int'(wr_addr));
         wd.push_back(int'(wr_data));
         wc.push_back(cyc);
      end
      if (done) begin
         ndone++;
         done_cyc         = cyc;
         busy_at_done     = busy;
         busy_before_done = prev_busy;
      end
      prev_busy = busy;
      #1;
      if (ramp) adc_data = adc_data + 12'd1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_log();
      wa.delete();
      wd.delete();
      wc.delete();
      ndone = 0;
   endtask

   initial begin
      // reset state
      steps(3);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;
      step();

      // cap_len=4, decim=0, ramp from 100, trigger 3 cycles after start
      clear_log();
      cap_len = 4'd4; decim = 8'd0; adc_data = 12'd100; ramp = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t1_busy_armed", busy, 1);
      steps(2);
      ext_trig = 1'b1;
      step();
      tcyc = cyc;
      ext_trig = 1'b0;
      steps(10);
      ramp = 1'b0;
      chk("t1_nw", wa.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < wa.size()) begin
            chk($sformatf("t1_addr%0d", i), wa[i], i);
            chk($sformatf("t1_data%0d", i), wd[i], 104 + i);
            chk($sformatf("t1_cyc%0d", i), wc[i], tcyc + 1 + i);
         end
      end
      chk("t1_ndone", ndone, 1);
      if (wc.size() == 4) chk("t1_done_cyc", done_cyc, wc[3] + 1);
      chk("t1_busy_at_done", busy_at_done, 0);
      chk("t1_busy_before_done", busy_before_done, 1);

      // cap_len=3, decim=2: one write every third cycle
      clear_log();
      cap_len = 4'd3; decim = 8'd2; adc_data = 12'd500; ramp = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0; ext_trig = 1'b1;
      step();
      ext_trig = 1'b0;
      steps(14);
      ramp = 1'b0;
      chk("t2_nw", wa.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < wa.size()) begin
            chk($sformatf("t2_addr%0d", i), wa[i], i);
            chk($sformatf("t2_data%0d", i), wd[i], 502 + 3 * i);
         end
      end
      if (wc.size() == 3) begin
         chk("t2_gap1", wc[1] - wc[0], 3);
         chk("t2_gap2", wc[2] - wc[1], 3);
         chk("t2_done_cyc", done_cyc, wc[2] + 1);
      end
      chk("t2_ndone", ndone, 1);

      // cap_len=0: full 16-entry depth with pointer wrap as the terminal write
      clear_log();
      cap_len = 4'd0; decim = 8'd0; adc_data = 12'd7;
      start = 1'b1;
      step();
      start = 1'b0; ext_trig = 1'b1;
      step();
      ext_trig = 1'b0;
      steps(25);
      chk("t3_nw", wa.size(), 16);
      for (int i = 0; i < 16; i++) begin
         if (i < wa.size()) chk($sformatf("t3_addr%0d", i), wa[i], i);
      end
      chk("t3_ndone", ndone, 1);
      if (wc.size() == 16) chk("t3_done_cyc", done_cyc, wc[15] + 1);

      // abort after two writes of cap_len=8, then restart from address 0
      clear_log();
      cap_len = 4'd8; decim = 8'd0;
      start = 1'b1;
      step();
      start = 1'b0; ext_trig = 1'b1;
      step();
      ext_trig = 1'b0;
      steps(2);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t4_abort_wr_en", wr_en, 0);
      chk("t4_abort_busy", busy, 0);
      steps(8);
      chk("t4_nw", wa.size(), 2);
      chk("t4_ndone", ndone, 0);
      clear_log();
      cap_len = 4'd2;
      start = 1'b1;
      step();
      start = 1'b0; ext_trig = 1'b1;
      step();
      ext_trig = 1'b0;
      steps(6);
      chk("t4r_nw", wa.size(), 2);
      if (wa.size() > 0) chk("t4r_addr0", wa[0], 0);
      chk("t4r_ndone", ndone, 1);

      // trigger coincident with start is ignored; start during capture is ignored
      clear_log();
      cap_len = 4'd3; decim = 8'd0;
      start = 1'b1; ext_trig = 1'b1;
      step();
      start = 1'b0; ext_trig = 1'b0;
      steps(3);
      chk("t5_no_early_wr", wa.size(), 0);
      chk("t5_busy_armed", busy, 1);
      ext_trig = 1'b1;
      step();
      ext_trig = 1'b0;
      step();
      start = 1'b1; cap_len = 4'd9;
      step();
      start = 1'b0;
      steps(6);
      chk("t5_nw", wa.size(), 3);
      chk("t5_ndone", ndone, 1);
      if (wa.size() == 3) chk("t5_addr2", wa[2], 2);

      // synchronous reset mid-capture: no done pulse, outputs cleared
      clear_log();
      cap_len = 4'd8;
      start = 1'b1;
      step();
      start = 1'b0; ext_trig = 1'b1;
      step();
      ext_trig = 1'b0;
      steps(2);
      rst_n = 1'b0;
      step();
      chk("t6_rst_wr_en", wr_en, 0);
      chk("t6_rst_busy", busy, 0);
      rst_n = 1'b1;
      nsave = wa.size();
      steps(8);
      chk("t6_nw_after", wa.size(), nsave);
      chk("t6_ndone", ndone, 0);

      // steady sample above threshold with ext_trig low never triggers
      clear_log();
      cap_len = 4'd1; trig_level = 12'd2048; adc_data = 12'd2100;
      start = 1'b1;
      step();
      start = 1'b0;
      steps(5);
      chk("t7_steady_nw", wa.size(), 0);
      chk("t7_steady_busy", busy, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      step();

`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
      // rising crossing of trig_level starts capture
      clear_log();
      adc_data = 12'd2000;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      adc_data = 12'd2100;
      steps(5);
      chk("t8_cross_nw", wa.size(), 1);
      if (wa.size() > 0) chk("t8_cross_data", wd[0], 2100);
      chk("t8_cross_ndone", ndone, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
- Sequences one capture of 12-bit latched ADC samples into an external sample RAM.
- Software arms the block, it waits for a trigger, then writes a programmed number of samples, optionally decimated.
- Sits between the ADC data latch output and the sample-buffer RAM write port.
- Reports busy/done to the control interface.

Parameters:
DATA_W, 12, ADC sample width
ADDR_W, 10, sample RAM address width; max capture depth 2^ADDR_W
DEC_W, 8, decimation divisor width

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle arm request
abort  in  1  one-cycle cancel request
ext_trig  in  1  external trigger, level, synchronous to clk
cap_len  in  ADDR_W  samples to capture; 0 = 2^ADDR_W
decim  in  DEC_W  keep one sample every decim+1 clocks
adc_data  in  DATA_W  latched ADC sample
trig_level  in  DATA_W  level-trigger threshold (used only with LEVEL_TRIG_EN)
wr_en  out  1  RAM write strobe
wr_addr  out  ADDR_W  RAM write address
wr_data  out  DATA_W  RAM write data
busy  out  1  high in ARMED or CAPTURE
done  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low.
- Reset values: state=IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0; all counters 0.
- All outputs are registered.
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE -> ARMED: on start. cap_len and decim are latched at this edge and held for the whole capture.
- ARMED -> CAPTURE: on the first cycle in ARMED where trig_hit=1. A trigger in the same cycle as start is ignored.
- On entry to CAPTURE: decimation counter=0, write pointer=0, write count=0.
- CAPTURE:
  - A strobe occurs in each cycle where the decimation counter equals 0. The counter counts 0..decim, then wraps to 0.
  - On a strobe edge: wr_en<=1, wr_data<=adc_data, wr_addr<=pointer; pointer and count then increment.
  - Otherwise wr_en<=0.
  - First write occurs on the first clock edge after entering CAPTURE.
  - decim=0: write every cycle. decim=3: every 4th cycle.
- CAPTURE -> DONE: at the edge issuing write number L, where L = latched cap_len, or 2^ADDR_W if cap_len=0.
- DONE: done=1 and wr_en=0 for exactly one cycle, then IDLE.
- Pointer wrap: the pointer wraps to 0 after 2^ADDR_W-1. This only occurs as the terminal write when cap_len=0.
- busy = (state==ARMED || state==CAPTURE).
- abort:
  - In ARMED or CAPTURE: go to IDLE at the next edge, wr_en<=0, no done pulse.
  - abort has priority over start, trigger, and the final write in the same cycle.
- start while busy or in DONE: ignored.
- rst_n low mid-capture: all state returns to reset values at the next edge; no done pulse.
- trig_hit = ext_trig when LEVEL_TRIG_EN is not defined.

Optional Feature:
- Macro: ADC_CAPTURE_LEVEL_TRIG_EN.
- Defined:
  - trig_hit = ext_trig OR rising level crossing.
  - Rising level crossing: previous registered sample < trig_level AND current adc_data >= trig_level, unsigned compare.
  - The previous-sample register resets to all ones, so the first ARMED cycle cannot false-trigger.
- Undefined: trig_level is unused, there is no comparator or previous-sample register, and trig_hit = ext_trig.

Decomposition:
- Shared package adc_cap_pkg:
  - state encoding localparams (S_IDLE=2'd0, S_ARMED=2'd1, S_CAPTURE=2'd2, S_DONE=2'd3)
  - default widths DATA_W and ADDR_W
- One natural sub-module, adc_decim_strobe: decimation counter producing the strobe. Inputs clear and decim; output strobe.

Test Plan:
- cap_len=4, decim=0: start, ext_trig 3 cycles later, adc_data ramping 100,101,... -> 4 consecutive writes at addr 0..3 with data equal to the ramp values at those edges; done pulses once; busy falls with done.
- cap_len=3, decim=2 -> wr_en high every 3rd cycle at addr 0,1,2; exactly 3 writes; done pulses one cycle after the third write.
- cap_len=0, ADDR_W=4 -> 16 writes, addr 0..15; done after addr 15; no 17th write.
- abort after 2 writes of cap_len=8 -> IDLE next cycle; no further wr_en; no done. A subsequent start+trigger restarts at addr 0.
- start held with ext_trig high in the same cycle -> ARMED; capture begins only from a trigger sampled in ARMED. start pulse during CAPTURE -> ignored, write count unchanged.
- LEVEL_TRIG_EN, trig_level=2048, adc_data 2000 then 2100 while armed, ext_trig=0 -> CAPTURE entered. Sample held at 2100 steady -> no trigger.
